// File: rtl/source_sel_ctrl_pkg.sv
// Shared definitions for the source select controller and the 1080p timing generator.
package source_sel_ctrl_pkg;

    // 1080p60 horizontal timing, in pixel clocks
    localparam int H_FRONT = 88;
    localparam int H_SYNC  = 44;
    localparam int H_BACK  = 148;
    localparam int H_ACT   = 1920;
    localparam int H_TOTAL = H_FRONT + H_SYNC + H_BACK + H_ACT;

    // 1080p60 vertical timing, in lines
    localparam int V_FRONT = 4;
    localparam int V_SYNC  = 5;
    localparam int V_BACK  = 36;
    localparam int V_ACT   = 1080;
    localparam int V_TOTAL = V_FRONT + V_SYNC + V_BACK + V_ACT;

    // Lock and loss-of-input defaults: loss is two full frames without VSYNC
    localparam int LOCK_FRAMES_DEF  = 3;
    localparam int TIMEOUT_CLKS_DEF = 2 * H_TOTAL * V_TOTAL;

    // Counter widths
    localparam int PIX_W  = 12;
    localparam int LINE_W = 11;
    localparam int TO_W   = 24;
    localparam int GOOD_W = 4;
    localparam int LOSS_W = 8;

    // Controller states; 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HUNT   = 2'b01,
        LOCKED = 2'b10
    } selState_t;

endpackage

// File: rtl/source_sel_ctrl_timing_measure.sv
// Measures input DE/VSYNC timing and qualifies each input frame at its VSYNC rising edge.
// A frame is good when it was preceded by an arming VSYNC, every DE run was exactly
// hActive pixels wide, and it carried exactly vActive DE runs.
module source_sel_ctrl_timing_measure
    import source_sel_ctrl_pkg::*;
#(
    parameter int H_ACT        = 1920,
    parameter int V_ACT        = 1080,
    parameter int TIMEOUT_CLKS = 4950000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de,
    input  logic              vsync,
    output logic              vsRise,
    output logic              good,
    output logic              timeout,
    output logic [PIX_W-1:0]  actPix,
    output logic [LINE_W-1:0] actLines
);

    localparam logic [PIX_W-1:0]  H_ACT_V = PIX_W'(H_ACT);
    localparam logic [LINE_W-1:0] V_ACT_V = LINE_W'(V_ACT);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic              deD;
    logic              vsD;
    logic [PIX_W-1:0]  pixCnt;
    logic [PIX_W-1:0]  lastRun;
    logic [LINE_W-1:0] lineCnt;
    logic [TO_W-1:0]   toCnt;
    logic              frameBad;
    logic              armed;
    logic              deFall;
    logic              runBad;
    logic              toHit;

    assign vsRise  = vsync & ~vsD;
    assign deFall  = ~de & deD;
    assign runBad  = deFall & (pixCnt != H_ACT_V);
    assign toHit   = (toCnt == TO_LAST);
    // A VSYNC edge on the terminal count cycle wins over the timeout
    assign timeout = toHit & ~vsRise;
    assign good    = vsRise & armed & ~frameBad & (lineCnt == V_ACT_V);

    // Delayed copies of DE and VSYNC for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deD <= 1'b0;
            vsD <= 1'b0;
        end else begin
            deD <= de;
            vsD <= vsync;
        end
    end

    // Pixel counter: counts the current DE run and is zero outside runs, so a run that
    // straddles VSYNC simply keeps counting into the new frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixCnt  <= '0;
            lastRun <= '0;
        end else if (deFall) begin
            pixCnt  <= '0;
            lastRun <= pixCnt;
        end else if (de && (pixCnt != '1)) begin
            pixCnt  <= pixCnt + 1'b1;
        end
    end

    // Line counter and bad-run flag; a DE fall coinciding with VSYNC belongs to the new frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lineCnt  <= '0;
            frameBad <= 1'b0;
        end else if (vsRise) begin
            lineCnt  <= deFall ? LINE_W'(1) : '0;
            frameBad <= runBad;
        end else begin
            if (deFall && (lineCnt != '1)) begin
                lineCnt <= lineCnt + 1'b1;
            end
            if (runBad) begin
                frameBad <= 1'b1;
            end
        end
    end

    // Frame measurement snapshot and arming; a timeout disarms until the next VSYNC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            actPix   <= '0;
            actLines <= '0;
            armed    <= 1'b0;
        end else if (vsRise) begin
            actPix   <= lastRun;
            actLines <= lineCnt;
            armed    <= 1'b1;
        end else if (timeout) begin
            armed    <= 1'b0;
        end
    end

    // Loss-of-input counter: clocks since the last VSYNC edge, holding at the terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toCnt <= '0;
        end else if (vsRise) begin
            toCnt <= '0;
        end else if (!toHit) begin
            toCnt <= toCnt + 1'b1;
        end
    end

endmodule

// File: rtl/source_sel_ctrl.sv
// Frame-synchronous source controller: locks onto the input after LOCK_FRAMES good frames
// and switches the output mux only at input VSYNC, on loss of input, or on reset.
module source_sel_ctrl
    import source_sel_ctrl_pkg::*;
#(
    parameter int H_ACT        = source_sel_ctrl_pkg::H_ACT,
    parameter int V_ACT        = source_sel_ctrl_pkg::V_ACT,
    parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic              iODCK,
    input  logic              reset,
    input  logic              iDE,
    input  logic              iVSYNC,
    input  logic              iForce,
    output logic              oSW,
    output logic              oLOCK,
    output logic [1:0]        oSTATE,
    output logic [PIX_W-1:0]  oActPix,
    output logic [LINE_W-1:0] oActLines,
    output logic [LOSS_W-1:0] oLossCnt
);

    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_FRAMES - 1);

    logic              vsRise;
    logic              good;
    logic              timeout;
    selState_t         state;
    selState_t         stateNext;
    logic [GOOD_W-1:0] goodCnt;
    logic [GOOD_W-1:0] goodCntNext;
    logic [LOSS_W-1:0] lossCnt;
    logic [LOSS_W-1:0] lossCntNext;
    logic              lossInc;
    logic              swQ;
    logic              lockQ;

    source_sel_ctrl_timing_measure #(
        .H_ACT        (H_ACT),
        .V_ACT        (V_ACT),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) uMeasure (
        .clk      (iODCK),
        .reset    (reset),
        .de       (iDE),
        .vsync    (iVSYNC),
        .vsRise   (vsRise),
        .good     (good),
        .timeout  (timeout),
        .actPix   (oActPix),
        .actLines (oActLines)
    );

    // Next-state, good-frame counting and loss accounting
    always_comb begin
        stateNext   = state;
        goodCntNext = goodCnt;
        lossInc     = 1'b0;
        if (timeout) begin
            stateNext   = IDLE;
            goodCntNext = '0;
            lossInc     = (state == LOCKED);
        end else begin
            case (state)
                IDLE: begin
                    if (vsRise) begin
                        stateNext   = HUNT;
                        goodCntNext = '0;
                    end
                end
                HUNT: begin
                    if (vsRise) begin
                        if (good && !iForce) begin
                            if (goodCnt == LOCK_LAST) begin
                                stateNext   = LOCKED;
                                goodCntNext = '0;
                            end else begin
                                goodCntNext = goodCnt + 1'b1;
                            end
                        end else begin
                            goodCntNext = '0;
                        end
                    end
                end
                LOCKED: begin
                    // good already implies vsRise, so test vsRise explicitly for the exit
                    if (vsRise && (!good || iForce)) begin
                        stateNext   = HUNT;
                        goodCntNext = '0;
                        lossInc     = 1'b1;
                    end
                end
                default: begin
                    stateNext   = IDLE;
                    goodCntNext = '0;
                end
            endcase
        end
        lossCntNext = (lossInc && (lossCnt != '1)) ? lossCnt + 1'b1 : lossCnt;
    end

    // State, counters and registered mux select / lock outputs
    always_ff @(posedge iODCK or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            goodCnt <= '0;
            lossCnt <= '0;
            swQ     <= 1'b0;
            lockQ   <= 1'b0;
        end else begin
            state   <= stateNext;
            goodCnt <= goodCntNext;
            lossCnt <= lossCntNext;
            swQ     <= (stateNext == LOCKED);
            lockQ   <= (stateNext == LOCKED);
        end
    end

    assign oSW      = swQ;
    assign oLOCK    = lockQ;
    assign oSTATE   = state;
    assign oLossCnt = lossCnt;

endmodule

// File: tb/tb_source_sel_ctrl.sv
// Directed bench for source_sel_ctrl using a scaled-down frame: 16 active pixels per
// 24-clock line, 12 lines per 288-clock frame, lock after 3 frames, loss after 576 clocks.
module tb_source_sel_ctrl;

    localparam int H_ACT_T     = 16;
    localparam int V_ACT_T     = 8;
    localparam int LINE_CLKS   = 24;
    localparam int FRAME_LINES = 12;
    localparam int FRAME_CLKS  = LINE_CLKS * FRAME_LINES;
    localparam int LOCK_T      = 3;
    localparam int TIMEOUT_T   = 576;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_HUNT   = 2'b01;
    localparam logic [1:0] S_LOCKED = 2'b10;

    logic        iODCK = 1'b0;
    logic        reset;
    logic        iDE;
    logic        iVSYNC;
    logic        iForce;
    logic        oSW;
    logic        oLOCK;
    logic [1:0]  oSTATE;
    logic [11:0] oActPix;
    logic [10:0] oActLines;
    logic [7:0]  oLossCnt;

    int          nChecks = 0;
    int          nFails  = 0;
    logic        swAt1;
    logic [1:0]  stateAt1;

    source_sel_ctrl #(
        .H_ACT        (H_ACT_T),
        .V_ACT        (V_ACT_T),
        .LOCK_FRAMES  (LOCK_T),
        .TIMEOUT_CLKS (TIMEOUT_T)
    ) dut (
        .iODCK     (iODCK),
        .reset     (reset),
        .iDE       (iDE),
        .iVSYNC    (iVSYNC),
        .iForce    (iForce),
        .oSW       (oSW),
        .oLOCK     (oLOCK),
        .oSTATE    (oSTATE),
        .oActPix   (oActPix),
        .oActLines (oActLines),
        .oLossCnt  (oLossCnt)
    );

    // clock
    always #5 iODCK = ~iODCK;

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // One frame: VSYNC high for 4 clocks at the start of line 0, DE runs on lines
    // 2..2+nLines-1. Run badIdx is badW wide. iForce rises at clock forceAt (-1 = never).
    // Output state one clock after the VSYNC edge is captured in swAt1/stateAt1.
    task automatic sendFrame(input int nLines, input int badIdx, input int badW, input int forceAt);
        int line;
        int px;
        int w;
        for (int c = 0; c < FRAME_CLKS; c++) begin
            @(negedge iODCK);
            if (c == 1) begin
                swAt1    = oSW;
                stateAt1 = oSTATE;
            end
            line   = c / LINE_CLKS;
            px     = c % LINE_CLKS;
            w      = ((line - 2) == badIdx) ? badW : H_ACT_T;
            iVSYNC = (line == 0) && (px < 4);
            iDE    = (line >= 2) && (line < 2 + nLines) && (px < w);
            if (c == forceAt) iForce = 1'b1;
        end
    endtask

    task automatic idleClks(input int n);
        repeat (n) begin
            @(negedge iODCK);
            iVSYNC = 1'b0;
            iDE    = 1'b0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_sw"},    oSW,       0);
        checkVal({tag, "_lock"},  oLOCK,     0);
        checkVal({tag, "_state"}, oSTATE,    S_IDLE);
        checkVal({tag, "_pix"},   oActPix,   0);
        checkVal({tag, "_lines"}, oActLines, 0);
        checkVal({tag, "_loss"},  oLossCnt,  0);
    endtask

    initial begin
        reset  = 1'b0;
        iDE    = 1'b0;
        iVSYNC = 1'b0;
        iForce = 1'b0;
        repeat (3) @(negedge iODCK);
        checkAllZero("rst");
        reset = 1'b1;

        // Acquisition: IDLE -> HUNT on the first edge, lock one clock after the 4th edge
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f1_state", stateAt1, S_HUNT);
        checkVal("f1_pix",   oActPix,  0);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f2_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f3_state", stateAt1, S_HUNT);
        checkVal("f3_sw",    swAt1,    0);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f4_sw",    swAt1,    1);
        checkVal("f4_state", stateAt1, S_LOCKED);
        checkVal("f4_lock",  oLOCK,    1);
        checkVal("f4_pix",   oActPix,  16);
        checkVal("f4_lines", oActLines, 8);

        // Narrow DE run in the middle of a frame drops lock at the next edge
        sendFrame(V_ACT_T, 3, 15, -1);
        checkVal("f5_state", stateAt1, S_LOCKED);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f6_sw",    swAt1,    0);
        checkVal("f6_state", stateAt1, S_HUNT);
        checkVal("f6_loss",  oLossCnt, 1);
        checkVal("f6_pix",   oActPix,  16);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f7_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f8_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f9_sw",    swAt1,    1);

        // Short frame (7 lines) drops lock
        sendFrame(V_ACT_T - 1, -1, 0, -1);
        checkVal("f10_state", stateAt1, S_LOCKED);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f11_state", stateAt1, S_HUNT);
        checkVal("f11_lines", oActLines, 7);
        checkVal("f11_loss",  oLossCnt, 2);
        sendFrame(V_ACT_T, -1, 0, -1);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f13_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f14_sw",    swAt1,    1);

        // Loss of input: still LOCKED 575 clocks after the edge, IDLE at 576
        idleClks(TIMEOUT_T - FRAME_CLKS);
        @(negedge iODCK);
        checkVal("to575_state", oSTATE, S_LOCKED);
        @(negedge iODCK);
        checkVal("to576_state", oSTATE, S_IDLE);
        checkVal("to576_sw",    oSW,    0);
        checkVal("to576_loss",  oLossCnt, 3);

        // Reacquire; the first edge after a timeout only arms
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f15_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f17_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f18_sw",    swAt1,    1);

        // VSYNC edge on the terminal count cycle keeps lock
        idleClks(TIMEOUT_T - FRAME_CLKS);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f19_state", stateAt1, S_LOCKED);
        checkVal("f19_sw",    swAt1,    1);
        checkVal("f19_loss",  oLossCnt, 3);

        // Force mid-frame: select holds until the next edge
        sendFrame(V_ACT_T, -1, 0, 100);
        checkVal("f20_sw_mid", oSW, 1);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f21_sw",    swAt1,    0);
        checkVal("f21_state", stateAt1, S_HUNT);
        checkVal("f21_loss",  oLossCnt, 4);
        for (int f = 22; f <= 26; f++) begin
            sendFrame(V_ACT_T, -1, 0, -1);
            checkVal($sformatf("f%0d_force_state", f), stateAt1, S_HUNT);
        end
        iForce = 1'b0;
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f27_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f28_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("f29_sw",    swAt1,    1);

        // Asynchronous reset in the middle of a locked frame
        idleClks(50);
        checkVal("prerst_sw", oSW, 1);
        #3;
        reset = 1'b0;
        #1;
        checkAllZero("arst");
        @(negedge iODCK);
        reset = 1'b1;
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("r1_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("r3_state", stateAt1, S_HUNT);
        sendFrame(V_ACT_T, -1, 0, -1);
        checkVal("r4_sw",    swAt1,    1);
        checkVal("r4_loss",  oLossCnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
